iq_symbol_tx: RTL and testbench
===============================

# iq_symbol_tx

Baseband I/Q symbol transmitter: the send end of the 4-bit I/Q sample interface consumed by the constellation-density receiver. Accepts bytes over a valid/ready handshake and maps them to QPSK or 16-QAM constellation points. Emits one 4-bit offset-binary I and Q sample pair per clock, holding each symbol for SPS cycles, with a fixed preamble at the start of every frame. Used on-chip as a loopback and test source and off-chip to drive the receiver's ui_in/uio_in nibbles.

## Interface
- SPS, 4, samples per symbol; legal 1..16
- PREAMBLE_LEN, 8, preamble length in symbols; legal 1..255
- clk  in  1  single clock; all flops rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- byte_in  in  8  payload byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  block accepts byte_in this cycle; transfer = byte_valid & byte_ready
- mode  in  1  0 = QPSK, 1 = 16-QAM; sampled only on the IDLE-exit transfer
- i_out  out  4  I sample, offset binary, midscale 8
- q_out  out  4  Q sample, offset binary, midscale 8
- sym_strobe  out  1  high on first sample of each symbol
- tx_active  out  1  high while preamble or data is on i_out/q_out

## Operation
- FSM states: IDLE, PREAMBLE, DATA.
- IDLE: i_out = q_out = 8, tx_active = 0, byte_ready = 1. A transfer latches byte_in and mode into internal registers and moves to PREAMBLE.
- PREAMBLE: PREAMBLE_LEN symbols. Even index k gives (12,12). Odd index gives (4,4). byte_ready = 0. After the last sample of the last preamble symbol, move to DATA using the latched byte.
- DATA, QPSK: 4 symbols per byte, MSB pair first. Pair b1b0: b1 drives I, b0 drives Q. Bit 0 maps to 4, bit 1 maps to 12.
- DATA, 16-QAM: 2 symbols per byte, high nibble first. Nibble b3b2b1b0: b3b2 drives I, b1b0 drives Q. Gray levels: 00→2, 01→6, 11→10, 10→14.
- byte_ready in DATA is 1 only on the last sample of the last symbol of the current byte.
  - Transfer at that point: the new byte's first symbol starts next cycle with no gap, in the frame's latched mode.
  - No transfer at that point (underrun): the frame ends and the next cycle is IDLE.
- The mode input is ignored outside the IDLE transfer. A mode change mid-frame has no effect until the next frame.
- Counters:
  - sample_cnt runs 0..SPS-1.
  - sym_cnt runs 0..PREAMBLE_LEN-1 in PREAMBLE, 0..3 in QPSK data, 0..1 in 16-QAM data.
  - Both counters wrap to 0 on state or byte change.
- byte_ready is a combinational function of state and counters only. It does not depend on byte_valid.

## Timing
- Reset values, asserted asynchronously: state IDLE, i_out = q_out = 8, sym_strobe = 0, tx_active = 0, all counters 0, latched byte and mode cleared.
- byte_ready is 1 whenever state = IDLE, including the first cycle after rst_n deasserts.
- Reset mid-frame: outputs go to reset values immediately and any byte in flight is discarded.
- i_out, q_out, sym_strobe and tx_active are registered.
- For an IDLE transfer in cycle t:
  - Preamble symbol 0 is on the outputs at t+1, with tx_active = 1 and sym_strobe = 1.
  - Data symbol 0 starts at t+1+PREAMBLE_LEN·SPS.
- Each symbol is stable for exactly SPS cycles. sym_strobe is high for 1 cycle per symbol; with SPS = 1 it is high every active cycle.
- Frame end: the cycle after the final data sample, i_out = q_out = 8, tx_active = 0 and byte_ready = 1. A new transfer is possible in that same cycle.
- Throughput: QPSK takes 4·SPS cycles per byte; 16-QAM takes 2·SPS cycles per byte.

## Test plan
- Reset: hold rst_n low with random inputs → i_out = q_out = 8, tx_active = 0, sym_strobe = 0. Release → byte_ready = 1.
- QPSK single byte, SPS = 4, PREAMBLE_LEN = 8, byte 0xB4 transferred at t:
  - Cycles t+1..t+32 give 8 alternating preamble symbols, (12,12) then (4,4), each held 4 cycles.
  - Data symbols follow, each held 4 cycles: (12,4), (12,12), (4,12), (4,4).
  - At t+49: (8,8), tx_active = 0.
- 16-QAM byte 0x1E → after the preamble: (2,6) for SPS cycles, then (10,14); then IDLE.
- Back-to-back QPSK bytes 0xFF, 0x00 with byte_valid held high:
  - byte_ready pulses exactly on the last sample of 0xFF's last symbol.
  - (12,12)×4 symbols runs directly into (4,4)×4 symbols with no midscale gap and no second preamble.
- Mode toggled and byte_valid dropped mid-frame:
  - The frame stays in the latched mode.
  - Underrun returns to IDLE the cycle after the last sample.
  - Next frame starts with a fresh preamble in the newly sampled mode.
- Async reset asserted in DATA between clock edges → outputs reach reset values before the next edge. After release, the block idles until a new transfer arrives.

Source files
------------

// File: rtl/iq_symbol_tx.sv
// Purpose: byte-to-I/Q symbol transmitter (QPSK / 16-QAM) with a fixed preamble per frame.
// Latency: an IDLE transfer in cycle t puts preamble symbol 0 on the outputs at t+1.
// Backpressure: byte_ready is high in IDLE and on the last sample of each data byte only.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   byte_in/byte_valid    payload byte and its valid; byte_ready is the accept
//   mode                  0 = QPSK, 1 = 16-QAM; sampled only when a frame starts
//   i_out/q_out           4-bit offset-binary samples (midscale 8)
//   sym_strobe            first sample of every symbol
//   tx_active             preamble or data is being transmitted
module iq_symbol_tx #(
  parameter int SPS          = 4,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       mode,
  output logic [3:0] i_out,
  output logic [3:0] q_out,
  output logic       sym_strobe,
  output logic       tx_active
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } state_t;

  localparam int              SW          = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [SW-1:0]   SAMPLE_LAST = SW'(SPS - 1);
  localparam logic [7:0]      PRE_LAST    = 8'(PREAMBLE_LEN - 1);
  localparam logic [3:0]      MIDSCALE    = 4'd8;

  // Counters describe the sample currently on the outputs.
  state_t        state, state_nxt;
  logic [SW-1:0] sample_cnt, sample_nxt;
  logic [7:0]    sym_cnt, sym_nxt;
  logic [7:0]    byte_q, byte_nxt;
  logic          mode_q, mode_nxt;

  logic [3:0]    i_nxt, q_nxt;
  logic          strobe_nxt, active_nxt;

  logic          sample_last;
  logic [7:0]    data_sym_last;
  logic          xfer;

  assign sample_last   = (sample_cnt == SAMPLE_LAST);
  assign data_sym_last = mode_q ? 8'd1 : 8'd3;

  // Depends only on state and counters, never on byte_valid.
  assign byte_ready = (state == IDLE) ||
                      ((state == DATA) && sample_last && (sym_cnt == data_sym_last));
  assign xfer       = byte_valid && byte_ready;

  // Gray-coded 16-QAM amplitude levels.
  function automatic logic [3:0] qam_level(input logic [1:0] bits);
    logic [3:0] lvl;
    case (bits)
      2'b00:   lvl = 4'd2;
      2'b01:   lvl = 4'd6;
      2'b11:   lvl = 4'd10;
      default: lvl = 4'd14;
    endcase
    return lvl;
  endfunction

  function automatic logic [3:0] qpsk_level(input logic bit_v);
    return bit_v ? 4'd12 : 4'd4;
  endfunction

  // State register, counters, latched payload and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      sym_cnt    <= '0;
      byte_q     <= '0;
      mode_q     <= 1'b0;
      i_out      <= MIDSCALE;
      q_out      <= MIDSCALE;
      sym_strobe <= 1'b0;
      tx_active  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sample_cnt <= sample_nxt;
      sym_cnt    <= sym_nxt;
      byte_q     <= byte_nxt;
      mode_q     <= mode_nxt;
      i_out      <= i_nxt;
      q_out      <= q_nxt;
      sym_strobe <= strobe_nxt;
      tx_active  <= active_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt  = state;
    sample_nxt = sample_cnt;
    sym_nxt    = sym_cnt;
    byte_nxt   = byte_q;
    mode_nxt   = mode_q;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt  = PREAMBLE;
          sample_nxt = '0;
          sym_nxt    = '0;
          byte_nxt   = byte_in;
          mode_nxt   = mode;
        end
      end
      PREAMBLE: begin
        if (sample_last) begin
          sample_nxt = '0;
          if (sym_cnt == PRE_LAST) begin
            state_nxt = DATA;
            sym_nxt   = '0;
          end else begin
            sym_nxt = sym_cnt + 8'd1;
          end
        end else begin
          sample_nxt = sample_cnt + 1'b1;
        end
      end
      DATA: begin
        if (sample_last) begin
          sample_nxt = '0;
          if (sym_cnt == data_sym_last) begin
            sym_nxt = '0;
            if (xfer) begin
              // Seamless continuation in the frame's latched mode.
              byte_nxt = byte_in;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            sym_nxt = sym_cnt + 8'd1;
          end
        end else begin
          sample_nxt = sample_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        sample_nxt = '0;
        sym_nxt    = '0;
      end
    endcase
  end

  // Output values for the sample that becomes visible after the next edge.
  always_comb begin
    logic [1:0] pair;
    logic [3:0] nib;
    i_nxt      = MIDSCALE;
    q_nxt      = MIDSCALE;
    strobe_nxt = 1'b0;
    active_nxt = 1'b0;
    pair       = '0;
    nib        = '0;
    case (state_nxt)
      PREAMBLE: begin
        i_nxt      = sym_nxt[0] ? 4'd4 : 4'd12;
        q_nxt      = sym_nxt[0] ? 4'd4 : 4'd12;
        strobe_nxt = (sample_nxt == '0);
        active_nxt = 1'b1;
      end
      DATA: begin
        strobe_nxt = (sample_nxt == '0);
        active_nxt = 1'b1;
        if (mode_nxt) begin
          nib   = sym_nxt[0] ? byte_nxt[3:0] : byte_nxt[7:4];
          i_nxt = qam_level(nib[3:2]);
          q_nxt = qam_level(nib[1:0]);
        end else begin
          case (sym_nxt[1:0])
            2'd0:    pair = byte_nxt[7:6];
            2'd1:    pair = byte_nxt[5:4];
            2'd2:    pair = byte_nxt[3:2];
            default: pair = byte_nxt[1:0];
          endcase
          i_nxt = qpsk_level(pair[1]);
          q_nxt = qpsk_level(pair[0]);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iq_symbol_tx.sv
module tb_iq_symbol_tx;

  localparam int SPS = 4;
  localparam int PL  = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       mode;
  logic [3:0] i_out;
  logic [3:0] q_out;
  logic       sym_strobe;
  logic       tx_active;

  iq_symbol_tx #(.SPS(SPS), .PREAMBLE_LEN(PL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mode       (mode),
    .i_out      (i_out),
    .q_out      (q_out),
    .sym_strobe (sym_strobe),
    .tx_active  (tx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of samples still to be shown after the current one.
  typedef struct {
    logic [3:0] i;
    logic [3:0] q;
    logic       st;
    logic       tx;
  } smp_t;

  localparam smp_t IDLE_SMP = '{i: 4'd8, q: 4'd8, st: 1'b0, tx: 1'b0};

  smp_t pend[$];
  smp_t cur = IDLE_SMP;
  logic frame_mode = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gray_lvl(input int v);
    case (v)
      0:       return 4'd2;
      1:       return 4'd6;
      3:       return 4'd10;
      default: return 4'd14;
    endcase
  endfunction

  task automatic push_sym(input logic [3:0] i, input logic [3:0] q);
    for (int s = 0; s < SPS; s++) pend.push_back('{i: i, q: q, st: (s == 0), tx: 1'b1});
  endtask

  task automatic push_byte(input logic [7:0] b, input logic m);
    int v;
    if (!m) begin
      for (int k = 0; k < 4; k++) begin
        v = (int'(b) >> (6 - 2 * k)) % 4;
        push_sym((v / 2) ? 4'd12 : 4'd4, (v % 2) ? 4'd12 : 4'd4);
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        v = (k == 0) ? int'(b) / 16 : int'(b) % 16;
        push_sym(gray_lvl(v / 4), gray_lvl(v % 4));
      end
    end
  endtask

  // One clock: drive inputs, check readiness, advance model, check outputs.
  task automatic step(input logic v, input logic [7:0] b, input logic m, output bit xfer);
    byte_valid = v;
    byte_in    = b;
    mode       = m;
    #1;
    chk("byte_ready", {7'd0, byte_ready}, {7'd0, (pend.size() == 0)});
    xfer = v && (pend.size() == 0);
    if (xfer) begin
      if (!cur.tx) begin
        frame_mode = m;
        for (int k = 0; k < PL; k++) push_sym((k % 2) ? 4'd4 : 4'd12, (k % 2) ? 4'd4 : 4'd12);
      end
      push_byte(b, frame_mode);
    end
    @(posedge clk);
    cur = (pend.size() > 0) ? pend.pop_front() : IDLE_SMP;
    @(negedge clk);
    chk("i_out", {4'd0, i_out}, {4'd0, cur.i});
    chk("q_out", {4'd0, q_out}, {4'd0, cur.q});
    chk("sym_strobe", {7'd0, sym_strobe}, {7'd0, cur.st});
    chk("tx_active", {7'd0, tx_active}, {7'd0, cur.tx});
  endtask

  task automatic idle_steps(input int n);
    bit x;
    for (int k = 0; k < n; k++) step(1'b0, 8'($urandom), 1'($urandom), x);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit x;
    int n;

    // Reset with random inputs.
    rst_n      = 1'b0;
    byte_valid = 1'($urandom);
    byte_in    = 8'($urandom);
    mode       = 1'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_i", {4'd0, i_out}, 8'd8);
    chk("rst_q", {4'd0, q_out}, 8'd8);
    chk("rst_tx", {7'd0, tx_active}, 8'd0);
    chk("rst_strobe", {7'd0, sym_strobe}, 8'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", {7'd0, byte_ready}, 8'd1);
    @(negedge clk);

    // QPSK 0xB4.
    step(1'b1, 8'hB4, 1'b0, x);
    chk("b4_pre0_i", {4'd0, i_out}, 8'd12);
    chk("b4_pre0_strobe", {7'd0, sym_strobe}, 8'd1);
    idle_steps(32);
    chk("b4_d0_i", {4'd0, i_out}, 8'd12);
    chk("b4_d0_q", {4'd0, q_out}, 8'd4);
    idle_steps(16);
    chk("b4_end_i", {4'd0, i_out}, 8'd8);
    chk("b4_end_tx", {7'd0, tx_active}, 8'd0);

    // 16-QAM 0x1E.
    step(1'b1, 8'h1E, 1'b1, x);
    idle_steps(32);
    chk("qam_s0_i", {4'd0, i_out}, 8'd2);
    chk("qam_s0_q", {4'd0, q_out}, 8'd6);
    idle_steps(4);
    chk("qam_s1_i", {4'd0, i_out}, 8'd10);
    chk("qam_s1_q", {4'd0, q_out}, 8'd14);
    idle_steps(4);
    chk("qam_end_tx", {7'd0, tx_active}, 8'd0);

    // Back-to-back QPSK 0xFF then 0x00 with valid held high.
    step(1'b1, 8'hFF, 1'b0, x);
    n = 0;
    do begin
      step(1'b1, 8'h00, 1'b0, x);
      n++;
    end while (!x && n < 200);
    chk("b2b_accept_cycle", 8'(n), 8'd48);
    chk("b2b_next_i", {4'd0, i_out}, 8'd4);
    chk("b2b_next_strobe", {7'd0, sym_strobe}, 8'd1);
    idle_steps(17);
    chk("b2b_end_tx", {7'd0, tx_active}, 8'd0);

    // Mode toggling mid-frame, underrun, then a fresh QPSK frame.
    step(1'b1, 8'hA5, 1'b1, x);
    idle_steps(40);
    chk("toggle_end_tx", {7'd0, tx_active}, 8'd0);
    step(1'b1, 8'h3C, 1'b0, x);
    chk("toggle_new_pre_i", {4'd0, i_out}, 8'd12);
    idle_steps(48);

    // Asynchronous reset while in DATA.
    step(1'b1, 8'h96, 1'b0, x);
    idle_steps(PL * SPS + 3);
    rst_n = 1'b0;
    #1;
    chk("arst_i", {4'd0, i_out}, 8'd8);
    chk("arst_q", {4'd0, q_out}, 8'd8);
    chk("arst_tx", {7'd0, tx_active}, 8'd0);
    chk("arst_strobe", {7'd0, sym_strobe}, 8'd0);
    chk("arst_ready", {7'd0, byte_ready}, 8'd1);
    pend.delete();
    cur = IDLE_SMP;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    idle_steps(5);

    // Randomized traffic.
    for (int k = 0; k < 2500; k++) begin
      step(($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom), x);
    end
    idle_steps(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
